// File: rtl/data_mem_responder.sv
// Data-memory responder for the multicycle core's data port.
// Word RAM with programmable wait states and a ready/error handshake.
module data_mem_responder #(
    parameter logic [31:0] DATA_BASE   = 32'h10010000,
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dAddress,
    input  logic [31:0] dWriteData,
    input  logic [3:0]  dByteEn,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] dReadData,
    output logic        mem_ready,
    output logic        mem_err,
    output logic        busy
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic [3:0]      be_q;
    logic            wr_q;
    logic            err_q;
    logic [31:0]     rdata_q;
    logic            ready_q;
    logic            err_out_q;
    logic            busy_q;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            req;
    logic [29:0]     woff;
    logic [AW-1:0]   idx_d;
    logic            req_err;
    logic            commit;
    logic            ram_we;

    // DATA_BASE is word aligned, so the word offset is a 30-bit subtraction.
    assign req     = MemRead | MemWrite;
    assign woff    = dAddress[31:2] - DATA_BASE[31:2];
    assign idx_d   = woff[AW-1:0];
    assign req_err = (MemRead & MemWrite)
                   | (dAddress[1:0] != 2'b00)
                   | (dAddress < DATA_BASE)
                   | ({2'b00, woff} >= 32'(DEPTH_WORDS));

    assign commit = (state_q == BUSY) && req && (cnt_q == 4'd0);
    assign ram_we = commit && wr_q && !err_q;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            wdata_q   <= 32'd0;
            be_q      <= 4'd0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'd0;
            ready_q   <= 1'b0;
            err_out_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        idx_q   <= idx_d;
                        wdata_q <= dWriteData;
                        be_q    <= dByteEn;
                        wr_q    <= MemWrite;
                        err_q   <= req_err;
                        cnt_q   <= 4'(LATENCY - 1);
                        busy_q  <= 1'b1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (!req) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        ready_q   <= 1'b1;
                        err_out_q <= err_q;
                        state_q   <= DONE;
                        if (err_q) begin
                            rdata_q <= 32'd0;
                        end else if (!wr_q) begin
                            rdata_q <= mem[idx_q];
                        end
                    end
                end
                DONE: begin
                    ready_q   <= 1'b0;
                    err_out_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dReadData = rdata_q;
    assign mem_ready = ready_q;
    assign mem_err   = err_out_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder (LATENCY=2 and LATENCY=1).
// Expected results come from a shadow memory and an address-rule model.
module tb_data_mem_responder;

    localparam logic [31:0] BASE  = 32'h10010000;
    localparam logic [31:0] DEPTH = 32'd256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] a_addr, a_wd, a_rdata;
    logic [3:0]  a_be;
    logic        a_rd, a_wr, a_ready, a_err, a_busy;
    logic [31:0] b_addr, b_wd, b_rdata;
    logic [3:0]  b_be;
    logic        b_rd, b_wr, b_ready, b_err, b_busy;

    data_mem_responder #(
        .DATA_BASE(BASE), .DEPTH_WORDS(256), .LATENCY(2)
    ) dut (
        .clk(clk), .rst(rst),
        .dAddress(a_addr), .dWriteData(a_wd), .dByteEn(a_be),
        .MemRead(a_rd), .MemWrite(a_wr),
        .dReadData(a_rdata), .mem_ready(a_ready),
        .mem_err(a_err), .busy(a_busy)
    );

    data_mem_responder #(
        .DATA_BASE(BASE), .DEPTH_WORDS(256), .LATENCY(1)
    ) dut1 (
        .clk(clk), .rst(rst),
        .dAddress(b_addr), .dWriteData(b_wd), .dByteEn(b_be),
        .MemRead(b_rd), .MemWrite(b_wr),
        .dReadData(b_rdata), .mem_ready(b_ready),
        .mem_err(b_err), .busy(b_busy)
    );

    typedef struct {
        logic [31:0] data;
        logic        chk_data;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } req_t;

    exp_t        exp_q[$];
    logic [31:0] shadow [int];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic model_err(logic rd, logic wr, logic [31:0] a);
        logic [31:0] w;
        w = (a - BASE) >> 2;
        return (rd && wr) || (a[1:0] != 2'b00) || (a < BASE) || (w >= DEPTH);
    endfunction

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n,
                                          logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    // Drives one request on the LATENCY=2 port; called #1 after a posedge.
    task automatic run_req(input req_t r, output logic [31:0] gd,
                           output logic ge, output int lat, output logic to);
        a_addr = r.a; a_wd = r.d; a_be = r.be; a_rd = r.rd; a_wr = r.wr;
        lat = 0; to = 1'b1; gd = '0; ge = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (a_ready) begin
                lat = i - 1; to = 1'b0; gd = a_rdata; ge = a_err;
                break;
            end
        end
        a_rd = 1'b0; a_wr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic issue(input req_t r, output logic [31:0] gd,
                         output logic ge, output int lat, output logic to);
        exp_t        e;
        logic [31:0] old;
        e.err = model_err(r.rd, r.wr, r.a);
        e.lat = 2; e.chk_data = 1'b0; e.data = '0;
        if (e.err) begin
            e.chk_data = 1'b1;
        end else if (r.wr) begin
            old = shadow.exists(r.a) ? shadow[r.a] : 32'h0;
            shadow[r.a] = merge(old, r.d, r.be);
        end else if (shadow.exists(r.a)) begin
            e.chk_data = 1'b1; e.data = shadow[r.a];
        end
        exp_q.push_back(e);
        run_req(r, gd, ge, lat, to);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        a_addr = '0; a_wd = '0; a_be = '0; a_rd = 1'b0; a_wr = 1'b0;
        b_addr = '0; b_wd = '0; b_be = '0; b_rd = 1'b0; b_wr = 1'b0;
        #12;
        n_cmp++;
        if ({a_rdata, a_ready, a_err, a_busy} !== 35'd0) begin
            n_bad++;
            $display("FAIL reset: rdata=%h rdy=%b err=%b busy=%b, required all 0",
                     a_rdata, a_ready, a_err, a_busy);
        end
        n_cmp++;
        if ({b_rdata, b_ready, b_err, b_busy} !== 35'd0) begin
            n_bad++;
            $display("FAIL reset_l1: rdata=%h rdy=%b err=%b busy=%b, required all 0",
                     b_rdata, b_ready, b_err, b_busy);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        req_t t[$];
        logic [31:0] gd; logic ge, to; int lat; exp_t e;
        t.push_back('{1'b0, 1'b1, 32'h10010004, 32'hCAFEBABE, 4'hF});
        t.push_back('{1'b1, 1'b0, 32'h10010004, 32'h0, 4'h0});
        t.push_back('{1'b0, 1'b1, 32'h10010000, 32'h01020304, 4'hF});
        t.push_back('{1'b0, 1'b1, 32'h100103FC, 32'hA5A5A5A5, 4'hF});
        t.push_back('{1'b1, 1'b0, 32'h100103FC, 32'h0, 4'h0});
        t.push_back('{1'b1, 1'b0, 32'h10010000, 32'h0, 4'h0});
        foreach (t[i]) begin
            issue(t[i], gd, ge, lat, to);
            e = exp_q.pop_front();
            n_cmp++;
            if (to || lat !== e.lat || ge !== e.err ||
                (e.chk_data && gd !== e.data)) begin
                n_bad++;
                $display("FAIL write_read[%0d]: rdy=%b lat=%0d err=%b data=%h, required lat=%0d err=%b data=%h",
                         i, !to, lat, ge, gd, e.lat, e.err, e.data);
            end
        end
    endtask

    task automatic test_byte_lanes();
        req_t t[$];
        logic [31:0] gd; logic ge, to; int lat; exp_t e;
        t.push_back('{1'b0, 1'b1, 32'h10010004, 32'h00AA0000, 4'b0100});
        t.push_back('{1'b1, 1'b0, 32'h10010004, 32'h0, 4'h0});
        t.push_back('{1'b0, 1'b1, 32'h10010000, 32'h77665544, 4'b1001});
        t.push_back('{1'b0, 1'b1, 32'h10010000, 32'hFFFFFFFF, 4'b0000});
        t.push_back('{1'b1, 1'b0, 32'h10010000, 32'h0, 4'h0});
        foreach (t[i]) begin
            issue(t[i], gd, ge, lat, to);
            e = exp_q.pop_front();
            n_cmp++;
            if (to || lat !== e.lat || ge !== e.err ||
                (e.chk_data && gd !== e.data)) begin
                n_bad++;
                $display("FAIL byte_lanes[%0d]: rdy=%b lat=%0d err=%b data=%h, required lat=%0d err=%b data=%h",
                         i, !to, lat, ge, gd, e.lat, e.err, e.data);
            end
        end
    endtask

    task automatic test_errors();
        req_t t[$];
        logic [31:0] gd; logic ge, to; int lat; exp_t e;
        t.push_back('{1'b1, 1'b0, 32'h10010002, 32'h0, 4'h0});
        t.push_back('{1'b1, 1'b0, 32'h1000FFFC, 32'h0, 4'h0});
        t.push_back('{1'b1, 1'b0, 32'h10010400, 32'h0, 4'h0});
        t.push_back('{1'b1, 1'b1, 32'h10010004, 32'h0, 4'hF});
        t.push_back('{1'b0, 1'b1, 32'h10010006, 32'h0, 4'hF});
        t.push_back('{1'b0, 1'b1, 32'h00010004, 32'h0, 4'hF});
        t.push_back('{1'b1, 1'b0, 32'h10010004, 32'h0, 4'h0});
        t.push_back('{1'b1, 1'b0, 32'h100103FC, 32'h0, 4'h0});
        foreach (t[i]) begin
            issue(t[i], gd, ge, lat, to);
            e = exp_q.pop_front();
            n_cmp++;
            if (to || lat !== e.lat || ge !== e.err ||
                (e.chk_data && gd !== e.data)) begin
                n_bad++;
                $display("FAIL errors[%0d]: rdy=%b lat=%0d err=%b data=%h, required lat=%0d err=%b data=%h",
                         i, !to, lat, ge, gd, e.lat, e.err, e.data);
            end
        end
    endtask

    task automatic test_abort();
        req_t r;
        logic [31:0] gd; logic ge, to; int lat; exp_t e;
        logic seen;
        r = '{1'b0, 1'b1, 32'h10010008, 32'h55AA55AA, 4'hF};
        issue(r, gd, ge, lat, to);
        e = exp_q.pop_front();
        n_cmp++;
        if (to || lat !== e.lat || ge !== e.err) begin
            n_bad++;
            $display("FAIL abort_setup: rdy=%b lat=%0d err=%b, required lat=%0d err=%b",
                     !to, lat, ge, e.lat, e.err);
        end
        a_addr = 32'h10010008; a_wd = 32'h12345678; a_be = 4'hF; a_wr = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a_wr = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (a_ready) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0 || a_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_ready: saw_ready=%b busy=%b, required 0 0",
                     seen, a_busy);
        end
        r = '{1'b1, 1'b0, 32'h10010008, 32'h0, 4'h0};
        issue(r, gd, ge, lat, to);
        e = exp_q.pop_front();
        n_cmp++;
        if (to || lat !== e.lat || ge !== e.err || gd !== e.data) begin
            n_bad++;
            $display("FAIL abort_readback: rdy=%b err=%b data=%h, required err=%b data=%h",
                     !to, ge, gd, e.err, e.data);
        end
    endtask

    task automatic test_reset_midop();
        req_t r;
        logic [31:0] gd; logic ge, to; int lat; exp_t e;
        a_addr = 32'h10010008; a_wd = 32'hDEADBEEF; a_be = 4'hF; a_wr = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (a_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL midop_busy: busy=%b, required 1", a_busy);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({a_rdata, a_ready, a_err, a_busy} !== 35'd0) begin
            n_bad++;
            $display("FAIL midop_reset: rdata=%h rdy=%b err=%b busy=%b, required all 0",
                     a_rdata, a_ready, a_err, a_busy);
        end
        a_wr = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        r = '{1'b1, 1'b0, 32'h10010008, 32'h0, 4'h0};
        issue(r, gd, ge, lat, to);
        e = exp_q.pop_front();
        n_cmp++;
        if (to || lat !== e.lat || ge !== e.err || gd !== e.data) begin
            n_bad++;
            $display("FAIL midop_readback: rdy=%b lat=%0d err=%b data=%h, required lat=%0d err=%b data=%h",
                     !to, lat, ge, gd, e.lat, e.err, e.data);
        end
    endtask

    task automatic test_back_to_back();
        logic rdy [1:12];
        logic bsy [1:12];
        logic any_err;
        int   r0, r1, lows, lat;
        exp_t e;
        logic to;
        logic [31:0] gd;
        b_addr = 32'h10010000; b_wd = 32'h11223344; b_be = 4'hF; b_wr = 1'b1;
        any_err = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            rdy[i] = b_ready; bsy[i] = b_busy;
            if (b_ready && b_err) any_err = 1'b1;
        end
        b_wr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        r0 = 0; r1 = 0;
        for (int i = 1; i <= 12; i++) begin
            if (rdy[i] === 1'b1) begin
                if (r0 == 0) r0 = i;
                else if (r1 == 0) r1 = i;
            end
        end
        lows = 0;
        if (r0 != 0 && r1 != 0)
            for (int i = r0 + 1; i < r1; i++)
                if (bsy[i] === 1'b0) lows++;
        n_cmp++;
        if (r0 != 2 || r1 - r0 != 3 || lows != 1 || any_err) begin
            n_bad++;
            $display("FAIL b2b_timing: first=%0d gap=%0d busy_low=%0d err=%b, required 2 3 1 0",
                     r0, r1 - r0, lows, any_err);
        end
        e.err = 1'b0; e.lat = 1; e.chk_data = 1'b1; e.data = 32'h11223344;
        exp_q.push_back(e);
        b_addr = 32'h10010000; b_rd = 1'b1;
        to = 1'b1; lat = 0; gd = '0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (b_ready) begin
                lat = i - 1; to = 1'b0; gd = b_rdata;
                break;
            end
        end
        b_rd = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (to || lat !== e.lat || gd !== e.data || b_err !== e.err) begin
            n_bad++;
            $display("FAIL b2b_read: rdy=%b lat=%0d data=%h err=%b, required lat=%0d data=%h err=%b",
                     !to, lat, gd, b_err, e.lat, e.data, e.err);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_errors();
        test_abort();
        test_reset_midop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
